// File: rtl/gray_mon_pkg.sv
// Shared encodings for the Gray sequence monitor: FSM states and error cause codes.
package gray_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_MULTI = 2'b01,
    ERR_ORDER = 2'b10,
    ERR_OVF   = 2'b11
  } err_e;

endpackage

// File: rtl/gray_monitor_if.sv
// Bundle between the Gray counter side (master) and the monitor (slave).
// Optional macro GRAY_MON_DOWN_EN adds the Dir output.
interface gray_monitor_if #(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned WRAP_W = 8
);

  logic [WIDTH-1:0]  GrayIn;
  logic              OverflowIn;
  logic              Resync;
  logic              Clear;
  logic [WIDTH-1:0]  BinOut;
  logic              Step;
  logic [WRAP_W-1:0] WrapCount;
  logic              Error;
  logic [1:0]        ErrCode;

`ifdef GRAY_MON_DOWN_EN
  logic              Dir;

  modport master (
    output GrayIn, OverflowIn, Resync, Clear,
    input  BinOut, Step, WrapCount, Error, ErrCode, Dir
  );

  modport slave (
    input  GrayIn, OverflowIn, Resync, Clear,
    output BinOut, Step, WrapCount, Error, ErrCode, Dir
  );
`else
  modport master (
    output GrayIn, OverflowIn, Resync, Clear,
    input  BinOut, Step, WrapCount, Error, ErrCode
  );

  modport slave (
    input  GrayIn, OverflowIn, Resync, Clear,
    output BinOut, Step, WrapCount, Error, ErrCode
  );
`endif

endinterface

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter.
module gray2bin #(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    o_bin = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/gray_monitor.sv
// Gray sequence monitor: converts sampled Gray codes to binary, checks single-step increments,
// counts wraps and latches a sticky error cause. Macro GRAY_MON_DOWN_EN also accepts decrements.
module gray_monitor
  import gray_mon_pkg::*;
#(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned WRAP_W = 8
) (
  input logic           Clk,
  input logic           Reset,
  gray_monitor_if.slave mon
);

  localparam logic [WIDTH-1:0] LsbOne = WIDTH'(1);

  state_e            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_prev_gray, w_prev_gray_nxt;
  logic              r_prev_ovf, w_prev_ovf_nxt;
  logic [WIDTH-1:0]  r_bin, w_bin_nxt;
  logic              r_step, w_step_nxt;
  logic [WRAP_W-1:0] r_wrap, w_wrap_nxt;
  logic              r_err, w_err_nxt;
  err_e              r_code, w_code_nxt;
  logic              r_dir, w_dir_nxt;

  logic [WIDTH-1:0]  w_bin_in, w_bin_prev, w_diff;
  logic              w_multi, w_inc, w_at_max;
  logic              w_accept, w_wrap_evt, w_down;
  err_e              w_fault;
`ifdef GRAY_MON_DOWN_EN
  logic              w_dec;
`endif

  gray2bin #(.WIDTH(WIDTH)) u_g2b_in (
    .i_gray (mon.GrayIn),
    .o_bin  (w_bin_in)
  );

  gray2bin #(.WIDTH(WIDTH)) u_g2b_prev (
    .i_gray (r_prev_gray),
    .o_bin  (w_bin_prev)
  );

  assign w_diff   = mon.GrayIn ^ r_prev_gray;
  // Clearing the lowest set bit leaves something only if more than one bit flipped.
  assign w_multi  = (w_diff & (w_diff - LsbOne)) != '0;
  assign w_inc    = w_bin_in == (w_bin_prev + LsbOne);
  assign w_at_max = &w_bin_prev;
`ifdef GRAY_MON_DOWN_EN
  assign w_dec    = w_bin_in == (w_bin_prev - LsbOne);
`endif

  // Classify the current sample against the previous accepted one.
  always_comb begin
    w_fault    = ERR_NONE;
    w_accept   = 1'b0;
    w_wrap_evt = 1'b0;
    w_down     = 1'b0;
    if (w_diff == '0) begin
      if (mon.OverflowIn != r_prev_ovf) w_fault = ERR_OVF;
    end else if (w_multi) begin
      w_fault = ERR_MULTI;
    end else if (w_inc) begin
      if (w_at_max) begin
        if (!mon.OverflowIn) begin
          w_fault = ERR_OVF;
        end else begin
          w_accept   = 1'b1;
          w_wrap_evt = 1'b1;
        end
      end else if (mon.OverflowIn != r_prev_ovf) begin
        w_fault = ERR_OVF;
      end else begin
        w_accept = 1'b1;
      end
`ifdef GRAY_MON_DOWN_EN
    end else if (w_dec) begin
      if (mon.OverflowIn != r_prev_ovf) begin
        w_fault = ERR_OVF;
      end else begin
        w_accept = 1'b1;
        w_down   = 1'b1;
      end
`endif
    end else begin
      w_fault = ERR_ORDER;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_prev_gray <= '0;
      r_prev_ovf  <= 1'b0;
      r_bin       <= '0;
      r_step      <= 1'b0;
      r_wrap      <= '0;
      r_err       <= 1'b0;
      r_code      <= ERR_NONE;
      r_dir       <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_prev_gray <= w_prev_gray_nxt;
      r_prev_ovf  <= w_prev_ovf_nxt;
      r_bin       <= w_bin_nxt;
      r_step      <= w_step_nxt;
      r_wrap      <= w_wrap_nxt;
      r_err       <= w_err_nxt;
      r_code      <= w_code_nxt;
      r_dir       <= w_dir_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (mon.Clear) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    w_state_nxt = TRACK;
        TRACK:   if (!mon.Resync && w_fault != ERR_NONE) w_state_nxt = ERROR;
        ERROR:   w_state_nxt = ERROR;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_prev_gray_nxt = r_prev_gray;
    w_prev_ovf_nxt  = r_prev_ovf;
    w_bin_nxt       = r_bin;
    w_step_nxt      = 1'b0;
    w_wrap_nxt      = r_wrap;
    w_err_nxt       = r_err;
    w_code_nxt      = r_code;
    w_dir_nxt       = r_dir;
    if (mon.Clear) begin
      w_err_nxt  = 1'b0;
      w_code_nxt = ERR_NONE;
      w_wrap_nxt = '0;
    end else if (r_state == IDLE || (r_state == TRACK && mon.Resync)) begin
      w_prev_gray_nxt = mon.GrayIn;
      w_prev_ovf_nxt  = mon.OverflowIn;
      w_bin_nxt       = w_bin_in;
    end else if (r_state == TRACK) begin
      if (w_fault != ERR_NONE) begin
        w_err_nxt  = 1'b1;
        w_code_nxt = w_fault;
      end else if (w_accept) begin
        w_step_nxt      = 1'b1;
        w_bin_nxt       = w_bin_in;
        w_prev_gray_nxt = mon.GrayIn;
        w_prev_ovf_nxt  = mon.OverflowIn;
        w_dir_nxt       = !w_down;
        if (w_wrap_evt && !(&r_wrap)) w_wrap_nxt = r_wrap + WRAP_W'(1);
      end
    end
  end

  assign mon.BinOut    = r_bin;
  assign mon.Step      = r_step;
  assign mon.WrapCount = r_wrap;
  assign mon.Error     = r_err;
  assign mon.ErrCode   = r_code;
`ifdef GRAY_MON_DOWN_EN
  assign mon.Dir       = r_dir;
`else
  logic w_unused_dir;
  assign w_unused_dir = r_dir;
`endif

endmodule

// File: tb/tb_gray_monitor.sv
// Table-driven bench for gray_monitor plus a wrap-counter saturation sequence.
module tb_gray_monitor;

  logic Clk = 1'b0;
  logic Reset;

  gray_monitor_if #(.WIDTH(3), .WRAP_W(8)) bus ();

  gray_monitor #(.WIDTH(3), .WRAP_W(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .mon   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst;
    logic       clr;
    logic       rsy;
    logic       ovf;
    logic [2:0] gray;
    logic [2:0] bin;
    logic       step;
    logic [7:0] wrap;
    logic       err;
    logic [1:0] code;
    logic       dir;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t v(logic rst, logic clr, logic rsy, logic ovf, logic [2:0] gray,
                             logic [2:0] bin, logic step, logic [7:0] wrap, logic err,
                             logic [1:0] code, logic dir);
    vec_t x;
    x.rst = rst; x.clr = clr; x.rsy = rsy; x.ovf = ovf; x.gray = gray;
    x.bin = bin; x.step = step; x.wrap = wrap; x.err = err; x.code = code; x.dir = dir;
    return x;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic clr, logic rsy, logic ovf, logic [2:0] gray);
    @(negedge Clk);
    Reset          = rst;
    bus.Clear      = clr;
    bus.Resync     = rsy;
    bus.OverflowIn = ovf;
    bus.GrayIn     = gray;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset          = 1'b1;
    bus.Clear      = 1'b0;
    bus.Resync     = 1'b0;
    bus.OverflowIn = 1'b0;
    bus.GrayIn     = 3'b000;

    // rst clr rsy ovf gray | bin step wrap err code dir
    vecs.push_back(v(1, 0, 0, 0, 3'b000, 3'd0, 0, 8'd0, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b000, 3'd0, 0, 8'd0, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b001, 3'd1, 1, 8'd0, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b011, 3'd2, 1, 8'd0, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b010, 3'd3, 1, 8'd0, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b110, 3'd4, 1, 8'd0, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b111, 3'd5, 1, 8'd0, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b101, 3'd6, 1, 8'd0, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b100, 3'd7, 1, 8'd0, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 1, 3'b000, 3'd0, 1, 8'd1, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 1, 3'b001, 3'd1, 1, 8'd1, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 1, 3'b011, 3'd2, 1, 8'd1, 0, 2'b00, 1));
    for (int i = 0; i < 5; i++) vecs.push_back(v(0, 0, 0, 1, 3'b011, 3'd2, 0, 8'd1, 0, 2'b00, 1));
    // Overflow falling without Resync, then Clear and re-capture
    vecs.push_back(v(0, 0, 0, 0, 3'b010, 3'd2, 0, 8'd1, 1, 2'b11, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b110, 3'd2, 0, 8'd1, 1, 2'b11, 1));
    vecs.push_back(v(0, 1, 0, 0, 3'b110, 3'd2, 0, 8'd0, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b111, 3'd5, 0, 8'd0, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b101, 3'd6, 1, 8'd0, 0, 2'b00, 1));
    // Overflow rising on 011->010
    vecs.push_back(v(1, 0, 0, 0, 3'b000, 3'd0, 0, 8'd0, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b011, 3'd2, 0, 8'd0, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 1, 3'b010, 3'd2, 0, 8'd0, 1, 2'b11, 1));
    // Resync from 110 to 000
    vecs.push_back(v(1, 0, 0, 0, 3'b000, 3'd0, 0, 8'd0, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b110, 3'd4, 0, 8'd0, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 1, 0, 3'b000, 3'd0, 0, 8'd0, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b001, 3'd1, 1, 8'd0, 0, 2'b00, 1));
    // Two bits change: error, then frozen
    vecs.push_back(v(1, 0, 0, 0, 3'b000, 3'd0, 0, 8'd0, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b001, 3'd1, 0, 8'd0, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b010, 3'd1, 0, 8'd0, 1, 2'b01, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b011, 3'd1, 0, 8'd0, 1, 2'b01, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b110, 3'd1, 0, 8'd0, 1, 2'b01, 1));
    // Reset leaves the error state; then decrement handling
    vecs.push_back(v(1, 0, 0, 0, 3'b000, 3'd0, 0, 8'd0, 0, 2'b00, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b011, 3'd2, 0, 8'd0, 0, 2'b00, 1));
`ifdef GRAY_MON_DOWN_EN
    vecs.push_back(v(0, 0, 0, 0, 3'b001, 3'd1, 1, 8'd0, 0, 2'b00, 0));
    vecs.push_back(v(0, 0, 0, 0, 3'b000, 3'd0, 1, 8'd0, 0, 2'b00, 0));
    vecs.push_back(v(0, 0, 0, 0, 3'b100, 3'd7, 1, 8'd0, 0, 2'b00, 0));
    vecs.push_back(v(0, 0, 0, 0, 3'b110, 3'd7, 0, 8'd0, 1, 2'b10, 0));
`else
    vecs.push_back(v(0, 0, 0, 0, 3'b001, 3'd2, 0, 8'd0, 1, 2'b10, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b000, 3'd2, 0, 8'd0, 1, 2'b10, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b100, 3'd2, 0, 8'd0, 1, 2'b10, 1));
    vecs.push_back(v(0, 0, 0, 0, 3'b110, 3'd2, 0, 8'd0, 1, 2'b10, 1));
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].clr, vecs[i].rsy, vecs[i].ovf, vecs[i].gray);
      check($sformatf("vec%0d BinOut", i), 32'(bus.BinOut), 32'(vecs[i].bin));
      check($sformatf("vec%0d Step", i), 32'(bus.Step), 32'(vecs[i].step));
      check($sformatf("vec%0d WrapCount", i), 32'(bus.WrapCount), 32'(vecs[i].wrap));
      check($sformatf("vec%0d Error", i), 32'(bus.Error), 32'(vecs[i].err));
      check($sformatf("vec%0d ErrCode", i), 32'(bus.ErrCode), 32'(vecs[i].code));
`ifdef GRAY_MON_DOWN_EN
      check($sformatf("vec%0d Dir", i), 32'(bus.Dir), 32'(vecs[i].dir));
`endif
    end

    // Wrap counter saturation: 260 full laps, overflow sticky after the first wrap
    drive(1, 0, 0, 0, 3'b000);
    drive(0, 0, 0, 0, 3'b000);
    for (int k = 1; k <= 260 * 8; k++) begin
      logic [2:0] b;
      b = 3'(k);
      drive(0, 0, 0, (k >= 8), b ^ (b >> 1));
      if (k == 254 * 8) check("wrap_254", 32'(bus.WrapCount), 32'd254);
      if (k == 255 * 8 + 3) check("step_mid_lap", 32'(bus.Step), 32'd1);
    end
    check("wrap_saturated", 32'(bus.WrapCount), 32'd255);
    check("wrap_sat_no_error", 32'(bus.Error), 32'd0);
    check("wrap_sat_bin", 32'(bus.BinOut), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
